// File: rtl/adc_spi_pkg.sv
// Shared definitions for the 8-channel 12-bit serial ADC link (master and responder).
package adc_spi_pkg;

  localparam int FLEN       = 16;
  localparam int DW         = 12;
  localparam int NCH        = 8;
  localparam int ADDR_FIRST = 2;
  localparam int ADDR_LAST  = 4;
  localparam int ZERO_LEAD  = 4;

  typedef logic [DW-1:0] adc_sample_t;
  typedef logic [2:0]    adc_chan_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } adc_state_t;

  // Serial bit for frame position pos: leading zeros, then the sample MSB first.
  function automatic logic frame_bit(input adc_sample_t smp, input logic [3:0] pos);
    logic [3:0] idx;
    idx = 4'(FLEN - 1) - pos;
    if (pos < 4'(ZERO_LEAD)) return 1'b0;
    return smp[idx];
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with rise/fall pulses
// taken from a third stage so both can never be high together.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic c50m,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync_p0, r_sync_p1, r_sync_p2;

  always_ff @(posedge c50m) begin
    if (rst) begin
      r_sync_p0 <= RST_VAL;
      r_sync_p1 <= RST_VAL;
      r_sync_p2 <= RST_VAL;
    end else begin
      r_sync_p0 <= i_async;
      r_sync_p1 <= r_sync_p0;
      r_sync_p2 <= r_sync_p1;
    end
  end

  assign o_sync = r_sync_p1;
  assign o_rise = r_sync_p1 & ~r_sync_p2;
  assign o_fall = ~r_sync_p1 & r_sync_p2;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating an 8-channel 12-bit serial ADC: decodes the channel
// address from din and streams samples from a host-loaded bank on dout.
module spi_adc_responder
  import adc_spi_pkg::*;
(
  input  logic        c50m,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic        ld_valid,
  input  adc_chan_t   ld_chan,
  input  adc_sample_t ld_data,
  output logic        frame_done,
  output adc_chan_t   addr_rx
);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_cs_s_unused, w_cs_rise, w_cs_fall;
  logic w_din_s, w_din_rise_unused, w_din_fall_unused;

  // cs_n syncs reset high so leaving reset never looks like a select.
  spi_edge_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .c50m(c50m), .rst(rst), .i_async(sclk),
    .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_edge_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .c50m(c50m), .rst(rst), .i_async(cs_n),
    .o_sync(w_cs_s_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_edge_sync #(.RST_VAL(1'b0)) u_sync_din (
    .c50m(c50m), .rst(rst), .i_async(din),
    .o_sync(w_din_s), .o_rise(w_din_rise_unused), .o_fall(w_din_fall_unused)
  );

  adc_state_t  r_state, w_state_nxt;
  logic [3:0]  r_rcnt, r_fcnt;
  adc_chan_t   r_addr_sh;
  adc_sample_t r_shreg;
  adc_sample_t r_bank [NCH];
  logic        r_frame_done;
  adc_chan_t   r_addr_rx;
  logic        w_snap, w_frame_end, w_unused_sclk;
  adc_chan_t   w_snap_chan;
  adc_sample_t w_snap_data;

  assign w_unused_sclk = w_sclk_s;

  always_ff @(posedge c50m) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_snap_chan = '0;
    w_frame_end = 1'b0;
    dout_oe     = 1'b0;
    dout        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_snap      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        dout_oe = 1'b1;
        dout    = frame_bit(r_shreg, r_fcnt);
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_fall && (r_fcnt == 4'(FLEN - 1))) begin
          w_snap      = 1'b1;
          w_snap_chan = r_addr_sh;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A bank write landing on the snapshot cycle must be seen by the new frame.
  assign w_snap_data = (ld_valid && (ld_chan == w_snap_chan)) ? ld_data : r_bank[w_snap_chan];

  always_ff @(posedge c50m) begin
    if (rst) begin
      r_rcnt       <= '0;
      r_fcnt       <= '0;
      r_addr_sh    <= '0;
      r_frame_done <= 1'b0;
      r_addr_rx    <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_addr_rx <= r_addr_sh;
      if ((r_state == ST_IDLE) || w_cs_rise) begin
        r_rcnt    <= '0;
        r_fcnt    <= '0;
        r_addr_sh <= '0;
      end else begin
        if (w_sclk_rise) begin
          r_rcnt <= r_rcnt + 4'd1;
          if ((r_rcnt >= 4'(ADDR_FIRST)) && (r_rcnt <= 4'(ADDR_LAST)))
            r_addr_sh <= {r_addr_sh[1:0], w_din_s};
        end
        if (w_sclk_fall) r_fcnt <= r_fcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge c50m) begin
    if (w_snap) r_shreg <= w_snap_data;
  end

  always_ff @(posedge c50m) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_bank[i] <= '0;
    end else if (ld_valid) begin
      r_bank[ld_chan] <= ld_data;
    end
  end

  assign frame_done = r_frame_done;
  assign addr_rx    = r_addr_rx;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: the bench acts as the ADC master.
`timescale 1ns/1ps
module tb_spi_adc_responder;

  logic        c50m = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        din = 1'b0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_chan = '0;
  logic [11:0] ld_data = '0;
  logic        dout, dout_oe, frame_done;
  logic [2:0]  addr_rx;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_wide = 0;
  int          fd_times[$];
  logic [2:0]  fd_addr = '0;
  logic        fd_prev = 1'b0;

  logic        ld_pend = 1'b0;
  int          ld_per = 0;
  logic [2:0]  ld_pch = '0;
  logic [11:0] ld_pdata = '0;

  spi_adc_responder dut (
    .c50m(c50m), .rst(rst), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ld_valid(ld_valid), .ld_chan(ld_chan),
    .ld_data(ld_data), .frame_done(frame_done), .addr_rx(addr_rx)
  );

  always #10 c50m = ~c50m;

  always @(posedge c50m) cyc <= cyc + 1;

  always @(negedge c50m) begin
    if (frame_done) begin
      fd_cnt++;
      fd_addr = addr_rx;
      fd_times.push_back(cyc);
      if (fd_prev) fd_wide++;
    end
    fd_prev = frame_done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c50m);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] ch, input logic [11:0] data);
    ld_valid = 1'b1;
    ld_chan  = ch;
    ld_data  = data;
    tick(1);
    ld_valid = 1'b0;
  endtask

  // One master frame of nper SCLK periods: 4 cycles low, 4 high, dout
  // sampled just before each rise. A pending load fires in period ld_per,
  // aligned with the cycle the responder acts on the preceding fall.
  task automatic run_frame(input logic [2:0] addr, input int nper, output logic [15:0] rx);
    logic [15:0] dword;
    dword = {2'b00, addr, 11'b0};
    rx = '0;
    for (int k = 0; k < nper; k++) begin
      din = dword[15-k];
      tick(2);
      if (ld_pend && (ld_per == k)) begin
        ld_valid = 1'b1;
        ld_chan  = ld_pch;
        ld_data  = ld_pdata;
      end
      tick(1);
      if (ld_valid) begin
        ld_valid = 1'b0;
        ld_pend  = 1'b0;
      end
      tick(1);
      rx[15-k] = dout;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    din = 1'b0;
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] rxv [8];
    int          base;
    int          n;

    // Reset with sclk toggling, after filling the bank with nonzero data
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) load(3'(i), 12'(4095 - i));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      tick(1);
    end
    sclk = 1'b0;
    check("rst_dout", {31'b0, dout}, 32'd0);
    check("rst_dout_oe", {31'b0, dout_oe}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_addr_rx", {29'b0, addr_rx}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);

    cs_n = 1'b0;
    tick(6);
    check("sel_dout_oe", {31'b0, dout_oe}, 32'd1);
    for (int f = 0; f < 8; f++) run_frame(3'(f + 1), 16, rxv[f]);
    for (int f = 0; f < 8; f++) check($sformatf("rst_bank_ch%0d", f), {16'b0, rxv[f]}, 32'd0);
    tick(4);
    cs_n = 1'b1;
    tick(6);

    // First frame: channel 0 after select, then the addressed channel
    load(3'd0, 12'hABC);
    load(3'd5, 12'h123);
    cs_n = 1'b0;
    tick(6);
    base = fd_cnt;
    run_frame(3'd5, 16, rx);
    check("first_frame_data", {16'b0, rx}, 32'h0ABC);
    tick(4);
    check("first_fd_count", fd_cnt - base, 32'd1);
    check("first_addr_rx", {29'b0, fd_addr}, 32'd5);
    run_frame(3'd0, 16, rx);
    check("second_frame_data", {16'b0, rx}, 32'h0123);
    tick(4);
    cs_n = 1'b1;
    tick(6);
    check("desel_dout_oe", {31'b0, dout_oe}, 32'd0);

    // Continuous SCLK, cs_n held low
    for (int i = 0; i < 8; i++) load(3'(i), 12'(257 * i));
    cs_n = 1'b0;
    tick(6);
    base = fd_cnt;
    run_frame(3'd7, 16, rxv[0]);
    run_frame(3'd0, 16, rxv[1]);
    run_frame(3'd3, 16, rxv[2]);
    run_frame(3'd0, 16, rxv[3]);
    tick(4);
    check("cont_f1", {16'b0, rxv[0]}, 32'h0000);
    check("cont_f2", {16'b0, rxv[1]}, 32'h0707);
    check("cont_f3", {16'b0, rxv[2]}, 32'h0000);
    check("cont_f4", {16'b0, rxv[3]}, 32'h0303);
    check("cont_fd_count", fd_cnt - base, 32'd4);
    n = fd_times.size();
    if (n >= 4) begin
      check("cont_gap1", fd_times[n-3] - fd_times[n-4], 32'd128);
      check("cont_gap2", fd_times[n-2] - fd_times[n-3], 32'd128);
      check("cont_gap3", fd_times[n-1] - fd_times[n-2], 32'd128);
    end else begin
      check("cont_fd_times", n, 32'd4);
    end
    cs_n = 1'b1;
    tick(6);

    // CS abort after 9 falls
    load(3'd0, 12'h0F0);
    cs_n = 1'b0;
    tick(6);
    base = fd_cnt;
    run_frame(3'd3, 9, rx);
    tick(2);
    cs_n = 1'b1;
    tick(3);
    check("abort_dout_oe", {31'b0, dout_oe}, 32'd0);
    tick(8);
    check("abort_no_fd", fd_cnt - base, 32'd0);
    cs_n = 1'b0;
    tick(6);
    run_frame(3'd6, 16, rx);
    check("abort_new_frame_ch0", {16'b0, rx}, 32'h00F0);

    // Write collisions: at frame end (bypass) and mid-frame (no effect)
    ld_pend = 1'b1; ld_per = 0; ld_pch = 3'd6; ld_pdata = 12'h5A5;
    run_frame(3'd6, 16, rx);
    check("collide_bypass", {16'b0, rx}, 32'h05A5);
    ld_pend = 1'b1; ld_per = 8; ld_pch = 3'd6; ld_pdata = 12'h111;
    run_frame(3'd6, 16, rx);
    check("midframe_inflight", {16'b0, rx}, 32'h05A5);
    run_frame(3'd0, 16, rx);
    check("midframe_written", {16'b0, rx}, 32'h0111);
    tick(4);
    cs_n = 1'b1;
    tick(6);

    // Reset in the middle of a frame at fcnt=7
    load(3'd0, 12'hFFF);
    cs_n = 1'b0;
    tick(6);
    run_frame(3'd5, 7, rx);
    tick(4);
    check("pre_rst_bits", {16'b0, rx}, 32'h0E00);
    check("pre_rst_dout", {31'b0, dout}, 32'd1);
    base = fd_cnt;
    rst = 1'b1;
    cs_n = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_dout", {31'b0, dout}, 32'd0);
    check("midrst_dout_oe", {31'b0, dout_oe}, 32'd0);
    tick(8);
    check("midrst_no_fd", fd_cnt - base, 32'd0);
    cs_n = 1'b0;
    tick(6);
    run_frame(3'd5, 16, rx);
    check("midrst_ch0_cleared", {16'b0, rx}, 32'h0000);
    tick(4);
    check("midrst_addr_rx", {29'b0, fd_addr}, 32'd5);
    run_frame(3'd0, 16, rx);
    check("midrst_ch5_cleared", {16'b0, rx}, 32'h0000);
    tick(4);
    cs_n = 1'b1;
    tick(6);
    check("fd_single_cycle", fd_wide, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
